wb_reg_bank: RTL and testbench
==============================

// Module: wb_reg_bank
// PURPOSE
//  Parametrised bank of NUM_REGS Wishbone B3 slave registers in a single address window.
//  Per-access mode is decoded from address bits: write, set, clear or invert.
//  Selected registers are read-only hardware inputs (RO_MASK). Write/read strobes go to
//  downstream logic. Ack is registered (one wait state); out-of-range and illegal
//  accesses raise err.
// PARAMETERS
//  DATA_WIDTH    32  bus/register width in bits
//  SELECT_WIDTH  4   number of sel lanes; granule = DATA_WIDTH/SELECT_WIDTH bits
//  NUM_REGS      4   registers in bank, >=1
//  RO_MASK       '0  NUM_REGS bits; bit i=1 -> reg i reads in[i], holds no storage
//  RESET_PAT     '0  NUM_REGS*DATA_WIDTH; slice i = reset value of reg i
//  TGD           2'h0 data tag driven on bus
// PORTS
//  clk      in   1                    bank clock, all state on posedge
//  reset_n  in   1                    asynchronous, active-low reset
//  bus      wishbone_b3.slave  -      register access port
//  in       in   NUM_REGS*DATA_WIDTH  slice i = read value of RO reg i
//  out      out  NUM_REGS*DATA_WIDTH  slice i = stored value of RW reg i; 0 for RO slices
//  wr_stb   out  NUM_REGS             1-cycle pulse: reg i updated by bus write
//  rd_stb   out  NUM_REGS             1-cycle pulse: reg i read by bus
// BEHAVIOUR
//  Address: SB=clog2(SELECT_WIDTH); mode=adr[SB+1:SB]; idx=adr[SB+2+IB-1:SB+2]
//    (IB=max(1,clog2(NUM_REGS))); higher adr bits ignored.
//  Modes per sel'd granule: 0 next=dat_m2s; 1 last|dat; 2 last&~dat; 3 last^dat.
//    Unsel'd granules keep value.
//  Request = cyc&stb&~ack_q&~err_q. On the clk edge after a request:
//    - legal (idx<NUM_REGS, and not (we & RO_MASK[idx])): ack_q<=1 for exactly one cycle.
//    - illegal: err_q<=1 for exactly one cycle; no state change, no strobes.
//    - legal write: reg committed on same edge; wr_stb[idx]=1 that cycle only if |sel.
//      A write with sel=0 is acked and leaves reg and wr_stb unchanged.
//    - legal read: dat_s2m registered on same edge (RW: stored value pre-write;
//      RO: in slice sampled); rd_stb[idx]=1 that cycle.
//  ack/err are deasserted the cycle after they assert. With stb held high, transfers
//    occur every 2nd cycle (ack 1,0,1,...).
//  dat_s2m holds last read data between transfers. rty=0 always. tgd_s2m=TGD.
//  A write followed by a read of the same reg returns the new value.
//  Master drops stb in the ack cycle: no effect. Reg state does not depend on the master
//    sampling ack.
//  Reset (reset_n=0, async): RW regs=RESET_PAT slices; ack, err, wr_stb, rd_stb, dat_s2m=0.
//    Takes effect immediately, mid-transfer included; a pending ack is lost.
//    Outstanding stb after release gets a fresh ack 1 cycle later.
//  RO slices of RESET_PAT are ignored.
// STRUCTURE
//  wb_reg_pkg:
//    typedef enum logic [1:0] {REG_WRITE, REG_SET, REG_CLEAR, REG_INVERT} reg_mode_e;
//    function reg_merge(last, dat, mode) for one granule.
//  Sub-module wb_reg_cell: one RW register with per-granule merge, enable and async reset.
//    Generated per reg with RO_MASK[i]=0.
//  Top level: address decode, legality check, ack/err FFs, read mux, strobe FFs.
// TESTING (DATA_WIDTH 32, SELECT_WIDTH 4, NUM_REGS 4, RO_MASK 4'b1000, reg0 reset 0x000000FF)
//  1 Release reset, read adr 0x00 -> ack 1 cycle after stb, dat_s2m=0x000000FF, rd_stb[0] pulse.
//  2 Reg1 sequence, sel F:
//      adr 0x10 dat 0xA5A50F0F -> 0xA5A50F0F
//      0x14 dat 0x0000F000 -> 0xA5A5FF0F
//      0x18 dat 0xA5000000 -> 0x00A5FF0F
//      0x1C dat 0xFFFFFFFF -> 0xFF5A00F0
//    out slice 1 matches after each ack; wr_stb[1] one pulse each.
//  3 Reg2=0, write adr 0x20 dat 0x12345678 sel 4'b0101 -> 0x00340078.
//    Then sel 0 write -> ack, no wr_stb, value kept.
//  4 in[3]=0xDEADBEEF: read 0x30 -> 0xDEADBEEF, rd_stb[3] pulse.
//    Write 0x30 -> err 1 cycle, ack 0, no strobe.
//  5 NUM_REGS=3 build: access adr 0x30 -> err 1 cycle, state unchanged.
//    stb held 4 cycles on reg0 -> ack 0,1,0,1.
//  6 Write reg1 0x1234, drop reset_n during ack cycle -> ack 0 at once, reg1=RESET_PAT.
//    Held stb after release -> ack 1 cycle later.

Source files
------------

// File: rtl/wb_reg_pkg.sv
// Shared types and helpers for the Wishbone register bank.
package wb_reg_pkg;

  // Access mode, taken from the two address bits just above the byte-lane offset.
  typedef enum logic [1:0] {
    REG_WRITE  = 2'd0,
    REG_SET    = 2'd1,
    REG_CLEAR  = 2'd2,
    REG_INVERT = 2'd3
  } reg_mode_e;

  // Merge rule for a granule. Every bit of a granule merges independently,
  // so the rule is expressed per bit and applied across the selected lanes.
  function automatic logic reg_merge(input logic last, input logic dat, input reg_mode_e mode);
    logic r;
    r = last;
    case (mode)
      REG_WRITE:  r = dat;
      REG_SET:    r = last | dat;
      REG_CLEAR:  r = last & ~dat;
      REG_INVERT: r = last ^ dat;
      default:    r = last;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_reg_cell.sv
// One read/write register with per-granule merge, write enable and async reset.
module wb_reg_cell
  import wb_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    SELECT_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SELECT_WIDTH-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat,
  output logic [DATA_WIDTH-1:0]   q
);

  localparam int GW = DATA_WIDTH / SELECT_WIDTH;

  reg_mode_e             mode_e;
  logic [DATA_WIDTH-1:0] nxt;

  assign mode_e = reg_mode_e'(mode);

  // Selected granules take the merged value; unselected granules hold.
  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
    assign nxt[b] = sel[b / GW] ? reg_merge(q[b], dat[b], mode_e) : q[b];
  end

  // Storage: commit the merged word on an enabled edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/wb_reg_bank.sv
// Wishbone B3 slave register bank: address-decoded write/set/clear/invert modes,
// read-only hardware inputs, registered ack/err (one wait state) and access strobes.
//
// Handshake: a request is cyc & stb while neither ack nor err is high. On the edge
// after a request exactly one of ack/err rises for one cycle; the slave ignores
// stb during that cycle, so a held stb yields one transfer every second cycle.
module wb_reg_bank
  import wb_reg_pkg::*;
#(
  parameter int                              DATA_WIDTH   = 32,
  parameter int                              SELECT_WIDTH = 4,
  parameter int                              NUM_REGS     = 4,
  parameter int                              ADR_WIDTH    = 32,
  parameter logic [NUM_REGS-1:0]             RO_MASK      = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_PAT    = '0,
  parameter logic [1:0]                      TGD          = 2'h0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           bus_cyc,
  input  logic                           bus_stb,
  input  logic                           bus_we,
  input  logic [ADR_WIDTH-1:0]           bus_adr,
  input  logic [SELECT_WIDTH-1:0]        bus_sel,
  input  logic [DATA_WIDTH-1:0]          bus_dat_m2s,
  output logic [DATA_WIDTH-1:0]          bus_dat_s2m,
  output logic                           bus_ack,
  output logic                           bus_err,
  output logic                           bus_rty,
  output logic [1:0]                     bus_tgd_s2m,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] out,
  output logic [NUM_REGS-1:0]            wr_stb,
  output logic [NUM_REGS-1:0]            rd_stb
);

  localparam int SB = $clog2(SELECT_WIDTH);
  localparam int IB = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [1:0]            mode;
  logic [IB-1:0]         idx;
  logic [NUM_REGS-1:0]   hit;
  logic                  idx_ok;
  logic                  ro_hit;
  logic                  legal;
  logic                  req;
  logic [NUM_REGS-1:0]   wr_en;
  logic [NUM_REGS-1:0]   rd_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] cell_q [NUM_REGS];
  logic                  unused_ok;

  assign mode = bus_adr[SB+1:SB];
  assign idx  = bus_adr[SB+2+IB-1:SB+2];

  // One-hot register decode; an index past the bank end hits nothing.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (idx == IB'(i));
    end
  end

  assign idx_ok = |hit;
  assign ro_hit = |(hit & RO_MASK);
  assign legal  = idx_ok & ~(bus_we & ro_hit);
  assign req    = bus_cyc & bus_stb & ~ack_q & ~err_q;

  // A zero-sel write is still acked but neither changes the register nor strobes.
  assign wr_en = {NUM_REGS{req & legal & bus_we & (|bus_sel)}} & hit & ~RO_MASK;
  assign rd_en = {NUM_REGS{req & legal & ~bus_we}} & hit;

  // Read mux: RO registers return the live hardware input, RW ones their storage.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit[i]) begin
        rdata = RO_MASK[i] ? in[i*DATA_WIDTH +: DATA_WIDTH] : cell_q[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (!RO_MASK[i]) begin : g_rw
      wb_reg_cell #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SELECT_WIDTH(SELECT_WIDTH),
        .RESET_VAL   (RESET_PAT[i*DATA_WIDTH +: DATA_WIDTH])
      ) u_cell (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (wr_en[i]),
        .mode   (mode),
        .sel    (bus_sel),
        .dat    (bus_dat_m2s),
        .q      (cell_q[i])
      );
    end else begin : g_ro
      assign cell_q[i] = '0;
    end
    assign out[i*DATA_WIDTH +: DATA_WIDTH] = cell_q[i];
  end

  // Response, read-data and strobe registers; all clear immediately on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      wr_stb <= '0;
      rd_stb <= '0;
      dat_q  <= '0;
    end else begin
      ack_q  <= req & legal;
      err_q  <= req & ~legal;
      wr_stb <= wr_en;
      rd_stb <= rd_en;
      if (|rd_en) begin
        dat_q <= rdata;
      end
    end
  end

  assign bus_ack     = ack_q;
  assign bus_err     = err_q;
  assign bus_rty     = 1'b0;
  assign bus_tgd_s2m = TGD;
  assign bus_dat_s2m = dat_q;

  // Upper address bits and RW slices of the input bus are intentionally ignored.
  assign unused_ok = ^{in, bus_adr};

endmodule

// File: tb/tb_wb_reg_bank.sv
// Self-checking bench for wb_reg_bank: directed scenarios with literal expectations,
// randomized accesses against a transaction-level model, plus a 3-register build.
module tb_wb_reg_bank;

  localparam logic [127:0] RESET4 = {96'h0, 32'h000000FF};
  localparam logic [95:0]  RESET3 = {32'h00000033, 32'h00000022, 32'h00000011};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (4 regs, reg3 read-only) ----------------
  logic         cyc = 0, stb = 0, we = 0;
  logic [31:0]  adr = 0, dat_m2s = 0;
  logic [3:0]   sel = 0;
  logic [31:0]  dat_s2m;
  logic         ack, err, rty;
  logic [1:0]   tgd;
  logic [127:0] in_bus = 0;
  logic [127:0] out_bus;
  logic [3:0]   wr_stb, rd_stb;

  wb_reg_bank #(
    .DATA_WIDTH(32), .SELECT_WIDTH(4), .NUM_REGS(4), .ADR_WIDTH(32),
    .RO_MASK(4'b1000), .RESET_PAT(RESET4), .TGD(2'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .bus_cyc(cyc), .bus_stb(stb), .bus_we(we), .bus_adr(adr), .bus_sel(sel),
    .bus_dat_m2s(dat_m2s), .bus_dat_s2m(dat_s2m), .bus_ack(ack), .bus_err(err),
    .bus_rty(rty), .bus_tgd_s2m(tgd),
    .in(in_bus), .out(out_bus), .wr_stb(wr_stb), .rd_stb(rd_stb)
  );

  // ---------------- second DUT (3 regs, all RW) ----------------
  logic         cyc3 = 0, stb3 = 0, we3 = 0;
  logic [31:0]  adr3 = 0, dat3_m2s = 0;
  logic [3:0]   sel3 = 0;
  logic [31:0]  dat3_s2m;
  logic         ack3, err3, rty3;
  logic [1:0]   tgd3;
  logic [95:0]  in3_bus = 0;
  logic [95:0]  out3_bus;
  logic [2:0]   wr3, rd3;

  wb_reg_bank #(
    .DATA_WIDTH(32), .SELECT_WIDTH(4), .NUM_REGS(3), .ADR_WIDTH(32),
    .RO_MASK(3'b000), .RESET_PAT(RESET3), .TGD(2'h0)
  ) dut3 (
    .clk(clk), .reset_n(reset_n),
    .bus_cyc(cyc3), .bus_stb(stb3), .bus_we(we3), .bus_adr(adr3), .bus_sel(sel3),
    .bus_dat_m2s(dat3_m2s), .bus_dat_s2m(dat3_s2m), .bus_ack(ack3), .bus_err(err3),
    .bus_rty(rty3), .bus_tgd_s2m(tgd3),
    .in(in3_bus), .out(out3_bus), .wr_stb(wr3), .rd_stb(rd3)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: each clock edge either services one request or not.
  logic [31:0] m_reg [4] = '{32'hFF, 32'h0, 32'h0, 32'h0};
  logic        e_ack = 0, e_err = 0;
  logic [3:0]  e_wr = 0, e_rd = 0;
  logic [31:0] e_dat = 0;

  always @(posedge clk or negedge reset_n) begin
    int          m_idx, m_mode;
    logic        m_req, m_legal;
    logic [31:0] mask, last, nv;
    if (!reset_n) begin
      m_reg[0] = 32'hFF; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 0;
      e_ack = 0; e_err = 0; e_wr = 0; e_rd = 0; e_dat = 0;
    end else begin
      m_req   = cyc && stb && !e_ack && !e_err;
      m_idx   = int'((adr / 16) % 4);
      m_mode  = int'((adr / 4) % 4);
      m_legal = !(we && m_idx == 3);
      mask = 0;
      for (int g = 0; g < 4; g++) if (sel[g]) mask = mask | (32'hFF << (8 * g));
      e_ack = m_req && m_legal;
      e_err = m_req && !m_legal;
      e_wr  = 0;
      e_rd  = 0;
      if (m_req && m_legal) begin
        if (we) begin
          last = m_reg[m_idx];
          case (m_mode)
            0:       nv = dat_m2s;
            1:       nv = last | dat_m2s;
            2:       nv = last & ~dat_m2s;
            default: nv = last ^ dat_m2s;
          endcase
          m_reg[m_idx] = (nv & mask) | (last & ~mask);
          if (sel != 0) e_wr[m_idx] = 1'b1;
        end else begin
          e_rd[m_idx] = 1'b1;
          e_dat = (m_idx == 3) ? in_bus[127:96] : m_reg[m_idx];
        end
      end
    end
  end

  // Compare process: every cycle, all outputs of the main DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", ack, e_ack);
      check("err", err, e_err);
      check("wr_stb", wr_stb, e_wr);
      check("rd_stb", rd_stb, e_rd);
      check("dat_s2m", dat_s2m, e_dat);
      check("out", out_bus, {32'h0, m_reg[2], m_reg[1], m_reg[0]});
      check("rty", rty, 1'b0);
      check("tgd", tgd, 2'h0);
    end
  end

  // ---------------- driver ----------------
  // Called just after a negedge; returns at the negedge where ack or err is seen.
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic got_ack, output logic got_err,
                        output logic [31:0] rdat, output logic [3:0] wst,
                        output logic [3:0] rst, output int lat);
    cyc = 1; stb = 1; we = w; adr = a; dat_m2s = d; sel = s;
    got_ack = 0; got_err = 0; rdat = 0; wst = 0; rst = 0; lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack || err) begin
        got_ack = ack; got_err = err; rdat = dat_s2m;
        wst = wr_stb; rst = rd_stb; lat = k + 1;
        break;
      end
    end
    cyc = 0; stb = 0; we = 0;
    if (!(got_ack || got_err)) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: no ack/err for adr %h within 8 cycles", a);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        ga, ge;
    logic [31:0] rd;
    logic [3:0]  ws, rs;
    int          lat;
    logic [31:0] seq_adr [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
    logic [31:0] seq_dat [4] = '{32'hA5A50F0F, 32'h0000F000, 32'hA5000000, 32'hFFFFFFFF};
    logic [31:0] seq_exp [4] = '{32'hA5A50F0F, 32'hA5A5FF0F, 32'h00A5FF0F, 32'hFF5A00F0};

    in_bus = {32'h0, $urandom, $urandom, $urandom};
    #2 reset_n = 0;
    repeat (3) @(negedge clk);
    check("reset ack", ack, 1'b0);
    check("reset dat_s2m", dat_s2m, 32'h0);
    check("reset out", out_bus, RESET4);
    reset_n = 1;
    chk_en = 1;
    @(negedge clk);

    // 1: read of reg0 returns its reset pattern after one wait state
    access(32'h00, 0, 0, 4'hF, ga, ge, rd, ws, rs, lat);
    check("t1 ack", ga, 1'b1);
    check("t1 latency", lat, 1);
    check("t1 data", rd, 32'h000000FF);
    check("t1 rd_stb", rs, 4'b0001);

    // 2: write/set/clear/invert sequence on reg1
    for (int i = 0; i < 4; i++) begin
      access(seq_adr[i], 1, seq_dat[i], 4'hF, ga, ge, rd, ws, rs, lat);
      check("t2 ack", ga, 1'b1);
      check("t2 out1", out_bus[63:32], seq_exp[i]);
      check("t2 wr_stb", ws, 4'b0010);
    end

    // 3: partial-lane write, then a zero-sel write
    access(32'h20, 1, 32'h12345678, 4'b0101, ga, ge, rd, ws, rs, lat);
    check("t3 out2", out_bus[95:64], 32'h00340078);
    access(32'h20, 1, 32'hFFFFFFFF, 4'b0000, ga, ge, rd, ws, rs, lat);
    check("t3 sel0 ack", ga, 1'b1);
    check("t3 sel0 wr_stb", ws, 4'b0000);
    check("t3 sel0 out2", out_bus[95:64], 32'h00340078);

    // 4: read-only register reads the input, rejects writes
    in_bus[127:96] = 32'hDEADBEEF;
    access(32'h30, 0, 0, 4'hF, ga, ge, rd, ws, rs, lat);
    check("t4 data", rd, 32'hDEADBEEF);
    check("t4 rd_stb", rs, 4'b1000);
    access(32'h30, 1, 32'h1, 4'hF, ga, ge, rd, ws, rs, lat);
    check("t4 err", ge, 1'b1);
    check("t4 ack", ga, 1'b0);
    check("t4 wr_stb", ws, 4'b0000);
    @(negedge clk);
    check("t4 err one cycle", err, 1'b0);

    // 6: reset dropped in the ack cycle, stb held through release
    cyc = 1; stb = 1; we = 1; adr = 32'h10; dat_m2s = 32'h1234; sel = 4'hF;
    @(posedge clk); #1;
    check("t6 ack", ack, 1'b1);
    check("t6 out1 written", out_bus[63:32], 32'h1234);
    #1 reset_n = 0;
    #1;
    check("t6 ack killed", ack, 1'b0);
    check("t6 out1 reset", out_bus[63:32], 32'h0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check("t6 fresh ack", ack, 1'b1);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      ra[5:4] = 2'($urandom_range(0, 3));
      ra[3:2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) in_bus = {$urandom, $urandom, $urandom, $urandom};
      access(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             ga, ge, rd, ws, rs, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // 5: three-register build: out-of-range index, then held stb
    cyc3 = 1; stb3 = 1; we3 = 0; adr3 = 32'h30; sel3 = 4'hF;
    @(negedge clk);
    check("t5 err", err3, 1'b1);
    check("t5 no ack", ack3, 1'b0);
    check("t5 no rd_stb", rd3, 3'b000);
    cyc3 = 0; stb3 = 0;
    @(negedge clk);
    check("t5 err one cycle", err3, 1'b0);
    check("t5 out unchanged", out3_bus, RESET3);
    cyc3 = 1; stb3 = 1; adr3 = 32'h00;
    check("t5 held ack c0", ack3, 1'b0);
    @(negedge clk);
    check("t5 held ack c1", ack3, 1'b1);
    check("t5 held data", dat3_s2m, 32'h11);
    @(negedge clk);
    check("t5 held ack c2", ack3, 1'b0);
    @(negedge clk);
    check("t5 held ack c3", ack3, 1'b1);
    cyc3 = 0; stb3 = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
